alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Command-side initiator for the 24-bit ALU in the multicycle datapath. It accepts a command from the control unit and drives the ALU's a/b/ALU_OP inputs. It captures the ALU's result and Z/C/N flags, then returns a registered response.
- Single-cycle ops pass straight through. CMP updates flags only. MUL is a fixed 24-iteration shift-add loop built from repeated ALU_OP_ADD.
- The ALU instance sits outside this block; this block is the other end of its interface.

Parameters:
- WIDTH, 24, datapath width; must match the ALU.
- MUL_STEPS, 24, multiply iterations; equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE.
- cmd_kind  input  2  0=SINGLE, 1=MUL, 2=CMP, 3=reserved (treated as SINGLE).
- cmd_op  input  3  ALU_OP for SINGLE; ignored for MUL/CMP.
- cmd_a  input  24  operand A / multiplicand.
- cmd_b  input  24  operand B / multiplier.
- alu_a  output  24  to ALU a.
- alu_b  output  24  to ALU b.
- alu_op  output  3  to ALU ALU_OP.
- alu_result  input  24  from ALU (combinational).
- alu_z, alu_c, alu_n  input  1 each  ALU flags.
- rsp_valid  output  1  one-cycle pulse; response valid.
- rsp_result  output  24  registered result; held until next response.
- flag_z, flag_c, flag_n  output  1 each  registered flags; held until next response.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; cmd_ready=1; rsp_valid=0.
  - rsp_result=0; flags=0; alu_a=alu_b=0; alu_op=ALU_OP_ADD.
  - Any in-flight command is discarded and produces no response.
- Accept:
  - A command is accepted when cmd_valid && cmd_ready at a rising edge.
  - Operands and kind are latched into internal registers. The command ports are not sampled again.
- FSM states: IDLE, EXEC, MUL_STEP, DONE.
  - IDLE -> EXEC on a SINGLE or CMP accept.
  - IDLE -> MUL_STEP on a MUL accept.
  - EXEC -> DONE after 1 cycle.
  - MUL_STEP -> DONE when the step counter reaches MUL_STEPS-1.
  - DONE -> IDLE after 1 cycle; rsp_valid=1 only in DONE.
- ALU outputs are registered. They are driven from the latched operands while in EXEC/MUL_STEP and hold their last value otherwise.
- SINGLE:
  - alu_a=A, alu_b=B, alu_op=cmd_op.
  - At the end of EXEC, rsp_result<=alu_result and the flags take the ALU flags.
  - Latency: accept edge T, rsp_valid high in cycle T+2.
- CMP:
  - alu_op=ALU_OP_SUB with A, B.
  - Flags are updated from the ALU; rsp_result keeps its previous value.
  - Same latency as SINGLE.
- MUL:
  - Initialise acc=0, mcand=A, mplier=B, cnt=0, sticky_c=0.
  - Each MUL_STEP cycle: alu_a=acc, alu_b=mcand, alu_op=ALU_OP_ADD.
  - If mplier[0] is set: acc<=alu_result and sticky_c|=alu_c.
  - Every step: mcand<<=1 (bits past bit 23 dropped); mplier>>=1; cnt++.
  - Result is the low 24 bits of A*B.
  - Flags: Z=(acc==0), N=acc[23], C=sticky_c (overflow hint only, not an exact overflow flag).
  - Latency: rsp_valid in cycle T+MUL_STEPS+1 (T+25); fixed, with no early exit when mplier==0.
- Back-to-back:
  - cmd_ready is low in EXEC, MUL_STEP and DONE.
  - The next command can be accepted in the cycle after DONE, so the minimum SINGLE throughput is 1 command per 3 cycles.
- cmd_valid while not ready: ignored. The requester must hold it until cmd_ready is high.
- Wrap-around: all ADD/SUB arithmetic is mod 2^24. The ALU's C and N are passed through unmodified.

Decomposition:
- ALU_OP_* constants come from the shared parameters.v include.
- Add CMD_SINGLE/CMD_MUL/CMD_CMP and the FSM state encodings to parameters.v.
- One natural sub-module: alu_seq_mul_ctrl, holding the acc/mcand/mplier/cnt datapath registers with step/load enables. The FSM stays in the top level.
- The test bench instantiates alu_sequencer wired to the existing ALU.

Test Plan:
- SINGLE ADD, A=500, B=500 -> rsp_valid at T+2; rsp_result=1000; Z=0, N=0, C=0.
- CMP, A=100, B=100 -> Z=1, N=0; rsp_result unchanged from the prior response (1000).
- SINGLE SUB, A=100, B=400 -> rsp_result=24'hFFFED4 (-300); N=1, Z=0.
- MUL, A=1234, B=567 -> rsp_valid at exactly T+25; rsp_result=699678; Z=0; cmd_ready low for 25 cycles after accept.
- MUL, A=24'h800000, B=2 -> rsp_result=0, Z=1. Then MUL A=0, B=24'hFFFFFF -> rsp_result=0, Z=1.
- Assert reset mid-MUL (cycle T+10) -> outputs return to reset values immediately; no rsp_valid. A new SINGLE ADD 1+2 after reset release -> 3.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: ALU opcodes, command kinds,
// FSM state encodings and the opcode-selection helper.
package alu_sequencer_pkg;

   localparam int DATA_W = 24;

   localparam logic [2:0] ALU_OP_ADD = 3'd0;
   localparam logic [2:0] ALU_OP_SUB = 3'd1;
   localparam logic [2:0] ALU_OP_AND = 3'd2;
   localparam logic [2:0] ALU_OP_OR  = 3'd3;
   localparam logic [2:0] ALU_OP_XOR = 3'd4;
   localparam logic [2:0] ALU_OP_NOT = 3'd5;
   localparam logic [2:0] ALU_OP_SLL = 3'd6;
   localparam logic [2:0] ALU_OP_SRL = 3'd7;

   localparam logic [1:0] CMD_SINGLE = 2'd0;
   localparam logic [1:0] CMD_MUL    = 2'd1;
   localparam logic [1:0] CMD_CMP    = 2'd2;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_EXEC     = 2'd1;
   localparam logic [1:0] ST_MUL_STEP = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   // CMP is a subtract whose result is discarded; the reserved kind behaves as SINGLE.
   function automatic logic [2:0] exec_op(input logic [1:0] kind, input logic [2:0] op);
      return (kind == CMD_CMP) ? ALU_OP_SUB : op;
   endfunction

endpackage

// File: rtl/alu_seq_mul_ctrl.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand/multiplier,
// step counter and sticky carry. Exposes next-state values so the ALU inputs can be registered in step.
module alu_seq_mul_ctrl
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter int MUL_STEPS = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_c,
   output logic [WIDTH-1:0] acc_d,
   output logic [WIDTH-1:0] mcand_d,
   output logic             sticky_c_d,
   output logic             last_step
);

   localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_c_q;

   assign last_step = (cnt_q == CNT_W'(MUL_STEPS - 1));

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      sticky_c_d = sticky_c_q;
      if (load) begin
         acc_d      = '0;
         mcand_d    = a;
         mplier_d   = b;
         cnt_d      = '0;
         sticky_c_d = 1'b0;
      end else if (step) begin
         if (mplier_q[0]) begin
            acc_d      = alu_result;
            sticky_c_d = sticky_c_q | alu_c;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: datapath registers are reset too, so an aborted multiply leaves no stale state behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         sticky_c_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, like real flops.
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         sticky_c_q <= sticky_c_d;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the external 24-bit ALU: runs single ops, CMP
// (flags only) and a fixed-length shift-add multiply, returning a registered response.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter int MUL_STEPS = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_kind,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_n,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       kind_q, kind_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             flag_z_q, flag_z_d, flag_c_q, flag_c_d, flag_n_q, flag_n_d;

   logic             mul_load, mul_step, mul_last, mul_sticky_d;
   logic [WIDTH-1:0] mul_acc_d, mul_mcand_d;

   alu_seq_mul_ctrl #(
      .WIDTH     (WIDTH),
      .MUL_STEPS (MUL_STEPS)
   ) u_mul_ctrl (
      .clk        (clk),
      .reset      (reset),
      .load       (mul_load),
      .step       (mul_step),
      .a          (cmd_a),
      .b          (cmd_b),
      .alu_result (alu_result),
      .alu_c      (alu_c),
      .acc_d      (mul_acc_d),
      .mcand_d    (mul_mcand_d),
      .sticky_c_d (mul_sticky_d),
      .last_step  (mul_last)
   );

   always_comb begin
      state_d      = state_q;
      kind_d       = kind_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      flag_z_d     = flag_z_q;
      flag_c_d     = flag_c_q;
      flag_n_d     = flag_n_q;
      mul_load     = 1'b0;
      mul_step     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               kind_d = cmd_kind;
               if (cmd_kind == CMD_MUL) begin
                  mul_load = 1'b1;
                  state_d  = ST_MUL_STEP;
                  alu_a_d  = mul_acc_d;
                  alu_b_d  = mul_mcand_d;
                  alu_op_d = ALU_OP_ADD;
               end else begin
                  state_d  = ST_EXEC;
                  alu_a_d  = cmd_a;
                  alu_b_d  = cmd_b;
                  alu_op_d = exec_op(cmd_kind, cmd_op);
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            if (kind_q != CMD_CMP) rsp_result_d = alu_result;
            flag_z_d = alu_z;
            flag_c_d = alu_c;
            flag_n_d = alu_n;
         end
         ST_MUL_STEP: begin
            // ALU inputs track the accumulator/multiplicand as they will be after this edge.
            mul_step = 1'b1;
            alu_a_d  = mul_acc_d;
            alu_b_d  = mul_mcand_d;
            if (mul_last) begin
               state_d      = ST_DONE;
               rsp_result_d = mul_acc_d;
               flag_z_d     = (mul_acc_d == '0);
               flag_c_d     = mul_sticky_d;
               flag_n_d     = mul_acc_d[WIDTH-1];
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         kind_q       <= CMD_SINGLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= ALU_OP_ADD;
         rsp_result_q <= '0;
         flag_z_q     <= 1'b0;
         flag_c_q     <= 1'b0;
         flag_n_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
         flag_z_q     <= flag_z_d;
         flag_c_q     <= flag_c_d;
         flag_n_q     <= flag_n_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_DONE);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_result = rsp_result_q;
   assign flag_z     = flag_z_q;
   assign flag_c     = flag_c_q;
   assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural 24-bit ALU, scoreboard of expected responses
// with latency, and directed plus random SINGLE/CMP/MUL commands including a mid-MUL reset.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int W = 24;

   logic         clk, reset;
   logic         cmd_valid, cmd_ready;
   logic [1:0]   cmd_kind;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_a, cmd_b;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_op;
   logic         alu_z, alu_c, alu_n;
   logic         rsp_valid;
   logic [W-1:0] rsp_result;
   logic         flag_z, flag_c, flag_n;

   typedef struct {
      logic [1:0]   kind;
      logic [W-1:0] res;
      logic         z, c, n;
      int           acc_cyc;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] last_res = '0;

   alu_sequencer #(.WIDTH(W), .MUL_STEPS(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_kind   (cmd_kind),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_z      (alu_z),
      .alu_c      (alu_c),
      .alu_n      (alu_n),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .flag_n     (flag_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: returns {carry, result}; SUB carry is the borrow.
   function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         ALU_OP_ADD: return {1'b0, a} + {1'b0, b};
         ALU_OP_SUB: return {1'b0, a} - {1'b0, b};
         ALU_OP_AND: return {1'b0, a & b};
         ALU_OP_OR:  return {1'b0, a | b};
         ALU_OP_XOR: return {1'b0, a ^ b};
         ALU_OP_NOT: return {1'b0, ~a};
         ALU_OP_SLL: return {a, 1'b0};
         default:    return {1'b0, 1'b0, a[W-1:1]};
      endcase
   endfunction

   always_comb begin
      logic [W:0] r;
      r          = alu_fn(alu_op, alu_a, alu_b);
      alu_result = r[W-1:0];
      alu_c      = r[W];
      alu_z      = (r[W-1:0] == '0);
      alu_n      = r[W-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_flags", {29'd0, flag_z, flag_c, flag_n}, {29'd0, e.z, e.c, e.n});
         end
      end
   end

   task automatic send(input logic [1:0] kind, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t       e;
      logic [W:0] r;
      logic [W:0] acc;
      logic [47:0] prod;
      int         n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b1;
      cmd_kind  = kind;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      cmd_op    = 3'($urandom);
      e.kind    = kind;
      e.acc_cyc = cyc;
      if (kind == CMD_MUL) begin
         prod     = 48'(a) * 48'(b);
         e.res    = prod[W-1:0];
         e.z      = (e.res == '0);
         e.n      = e.res[W-1];
         e.c      = 1'b0;
         acc      = '0;
         for (int i = 0; i < W; i++) begin
            if (b[i]) begin
               acc = {1'b0, acc[W-1:0]} + {1'b0, W'(a << i)};
               e.c = e.c | acc[W];
            end
         end
         e.lat    = W;
         last_res = e.res;
      end else begin
         r     = alu_fn((kind == CMD_CMP) ? ALU_OP_SUB : op, a, b);
         e.res = (kind == CMD_CMP) ? last_res : r[W-1:0];
         e.z   = (r[W-1:0] == '0);
         e.c   = r[W];
         e.n   = r[W-1];
         e.lat = 1;
         if (kind != CMD_CMP) last_res = r[W-1:0];
      end
      sb.push_back(e);
   endtask

   task automatic run_cmd(input logic [1:0] kind, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int lows = 0;
      int n = 0;
      send(kind, op, a, b);
      @(negedge clk);
      while (!cmd_ready && lows < 100) begin
         lows++;
         @(negedge clk);
      end
      check("ready_low_cycles", 32'(lows), (kind == CMD_MUL) ? 32'd25 : 32'd2);
      while (sb.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rsp_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_kind  = CMD_SINGLE;
      cmd_op    = ALU_OP_ADD;
      cmd_a     = '0;
      cmd_b     = '0;
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_result", 32'(rsp_result), 32'd0);
      check("rst_alu", {alu_a, alu_b[7:0]}, 32'd0);
      check("rst_alu_op_flags", {26'd0, alu_op, flag_z, flag_c, flag_n}, {26'd0, ALU_OP_ADD, 3'b000});
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_cmd(CMD_SINGLE, ALU_OP_ADD, 24'd500, 24'd500);
      check("add_result", 32'(rsp_result), 32'd1000);
      check("add_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b000);

      run_cmd(CMD_CMP, ALU_OP_XOR, 24'd100, 24'd100);
      check("cmp_keeps_result", 32'(rsp_result), 32'd1000);
      check("cmp_zn", {30'd0, flag_z, flag_n}, 32'b10);

      run_cmd(CMD_SINGLE, ALU_OP_SUB, 24'd100, 24'd400);
      check("sub_result", 32'(rsp_result), 32'hFFFED4);
      check("sub_zn", {30'd0, flag_z, flag_n}, 32'b01);

      run_cmd(CMD_MUL, ALU_OP_SUB, 24'd1234, 24'd567);
      check("mul_result", 32'(rsp_result), 32'd699678);
      check("mul_z", 32'(flag_z), 32'd0);

      run_cmd(CMD_MUL, ALU_OP_ADD, 24'h800000, 24'd2);
      check("mul_wrap_result", 32'(rsp_result), 32'd0);
      check("mul_wrap_z", 32'(flag_z), 32'd1);
      run_cmd(CMD_MUL, ALU_OP_ADD, 24'd0, 24'hFFFFFF);
      check("mul_zero_result", 32'(rsp_result), 32'd0);
      check("mul_zero_z", 32'(flag_z), 32'd1);

      run_cmd(CMD_SINGLE, ALU_OP_AND, 24'hF0F0F0, 24'hFF00FF);
      run_cmd(CMD_SINGLE, ALU_OP_OR, 24'h00F000, 24'h0000F0);
      run_cmd(CMD_SINGLE, ALU_OP_XOR, 24'hAAAAAA, 24'hAAAAAA);
      run_cmd(2'd3, ALU_OP_ADD, 24'hFFFFFF, 24'd1);
      run_cmd(CMD_CMP, ALU_OP_ADD, 24'd5, 24'd9);
      for (int i = 0; i < 4; i++) begin
         run_cmd(CMD_MUL, ALU_OP_ADD, W'($urandom), W'($urandom));
      end

      // Reset partway through a multiply: immediate reset values and no response.
      send(CMD_MUL, ALU_OP_ADD, 24'd1234, 24'd567);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_ready_valid", {30'd0, cmd_ready, rsp_valid}, 32'b10);
      check("midrst_result", 32'(rsp_result), 32'd0);
      check("midrst_alu", {alu_a, alu_b[7:0]}, 32'd0);
      check("midrst_alu_op_flags", {26'd0, alu_op, flag_z, flag_c, flag_n}, {26'd0, ALU_OP_ADD, 3'b000});
      sb.delete();
      last_res = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst_idle_ready", 32'(cmd_ready), 32'd1);

      run_cmd(CMD_SINGLE, ALU_OP_ADD, 24'd1, 24'd2);
      check("post_rst_add", 32'(rsp_result), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
